// File: rtl/csr_reg_pkg.sv
// Shared CSR map, bit positions, trap cause codes and interrupt FSM state type
// for the machine-mode CSR register file.
package csr_reg_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 12;

  localparam logic [ALEN-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [ALEN-1:0] CSR_MIE      = 12'h304;
  localparam logic [ALEN-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [ALEN-1:0] CSR_MEPC     = 12'h341;
  localparam logic [ALEN-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [ALEN-1:0] CSR_MIP      = 12'h344;
  localparam logic [ALEN-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [ALEN-1:0] CSR_MTIMECMP = 12'h7C0;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_TIMER_BIT    = 7;
  localparam int IRQ_EXT_BIT      = 11;

  localparam logic [XLEN-1:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [XLEN-1:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_TRAP   = 2'd1,
    ST_SETTLE = 2'd2
  } irq_state_e;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] pack_mstatus(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

  // mie and mip share the same layout: timer at bit 7, external at bit 11.
  function automatic logic [XLEN-1:0] pack_irq_bits(input logic timer, input logic ext);
    logic [XLEN-1:0] v;
    v = '0;
    v[IRQ_TIMER_BIT] = timer;
    v[IRQ_EXT_BIT]   = ext;
    return v;
  endfunction

endpackage

// File: rtl/csr_reg_irq_ctrl.sv
// Interrupt controller: pending/priority evaluation, RUN/TRAP/SETTLE sequencing,
// and the registered flush pulse and redirect target.
module csr_reg_irq_ctrl
  import csr_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mst_mie_i,
  input  logic                  mie_mtie_i,
  input  logic                  mie_meie_i,
  input  logic                  mtip_i,
  input  logic                  meip_i,
  input  logic                  mret_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  output logic                  trap_take_o,
  output logic                  mret_take_o,
  output logic [DATA_WIDTH-1:0] cause_o,
  output logic                  flush_interrupt_o,
  output logic [DATA_WIDTH-1:0] trap_pc_o
);

  irq_state_e state_r;
  logic       ext_hit_s;
  logic       tmr_hit_s;
  logic       in_run_s;

  assign ext_hit_s = mie_meie_i & meip_i;
  assign tmr_hit_s = mie_mtie_i & mtip_i;
  assign in_run_s  = (state_r == ST_RUN);

  // mret takes precedence over a pending interrupt in the same cycle.
  assign mret_take_o = in_run_s & mret_i;
  assign trap_take_o = in_run_s & ~mret_i & mst_mie_i & (ext_hit_s | tmr_hit_s);
  assign cause_o     = ext_hit_s ? CAUSE_EXT : CAUSE_TIMER;

  // Sequencer with registered flush pulse and redirect target.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r           <= ST_RUN;
      flush_interrupt_o <= 1'b0;
      trap_pc_o         <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mret_take_o) begin
            state_r           <= ST_TRAP;
            flush_interrupt_o <= 1'b1;
            trap_pc_o         <= mepc_i;
          end else if (trap_take_o) begin
            state_r           <= ST_TRAP;
            flush_interrupt_o <= 1'b1;
            trap_pc_o         <= mtvec_i;
          end else begin
            flush_interrupt_o <= 1'b0;
          end
        end
        ST_TRAP: begin
          state_r           <= ST_SETTLE;
          flush_interrupt_o <= 1'b0;
        end
        ST_SETTLE: begin
          state_r           <= ST_RUN;
          flush_interrupt_o <= 1'b0;
        end
        default: begin
          state_r           <= ST_RUN;
          flush_interrupt_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR register file: storage, write-through read mux, mcycle/mtimecmp
// timer, and the interrupt controller instance.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
  output logic [DATA_WIDTH-1:0]     csr_rdata_o,
  input  logic                      irq_ext_i,
  input  logic [DATA_WIDTH-1:0]     inst_pc_i,
  input  logic                      mret_i,
  output logic                      flush_interrupt_o,
  output logic [DATA_WIDTH-1:0]     trap_pc_o
);

  logic                  mst_mie_r;
  logic                  mst_mpie_r;
  logic                  mie_mtie_r;
  logic                  mie_meie_r;
  logic [DATA_WIDTH-1:0] mtvec_r;
  logic [DATA_WIDTH-1:0] mepc_r;
  logic [DATA_WIDTH-1:0] mcause_r;
  logic [DATA_WIDTH-1:0] mcycle_r;
  logic [DATA_WIDTH-1:0] mtimecmp_r;

  logic                  mtip_s;
  logic                  trap_take_s;
  logic                  mret_take_s;
  logic [DATA_WIDTH-1:0] cause_s;
  logic                  wr_ok_s;
  logic [DATA_WIDTH-1:0] wr_val_s;
  logic [DATA_WIDTH-1:0] rd_stored_s;

  assign mtip_s = (mcycle_r >= mtimecmp_r);

  csr_reg_irq_ctrl #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_irq_ctrl (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mst_mie_i        (mst_mie_r),
    .mie_mtie_i       (mie_mtie_r),
    .mie_meie_i       (mie_meie_r),
    .mtip_i           (mtip_s),
    .meip_i           (irq_ext_i),
    .mret_i           (mret_i),
    .mtvec_i          (mtvec_r),
    .mepc_i           (mepc_r),
    .trap_take_o      (trap_take_s),
    .mret_take_o      (mret_take_s),
    .cause_o          (cause_s),
    .flush_interrupt_o(flush_interrupt_o),
    .trap_pc_o        (trap_pc_o)
  );

  // Write value as it will be stored; also feeds the read bypass.
  always_comb begin
    wr_ok_s  = 1'b1;
    wr_val_s = csr_wdata_i;
    case (csr_waddr_i)
      CSR_MSTATUS:  wr_val_s = pack_mstatus(csr_wdata_i[MSTATUS_MIE_BIT], csr_wdata_i[MSTATUS_MPIE_BIT]);
      CSR_MIE:      wr_val_s = pack_irq_bits(csr_wdata_i[IRQ_TIMER_BIT], csr_wdata_i[IRQ_EXT_BIT]);
      CSR_MTVEC:    wr_val_s = align4(csr_wdata_i);
      CSR_MEPC:     wr_val_s = align4(csr_wdata_i);
      CSR_MCAUSE:   wr_val_s = csr_wdata_i;
      CSR_MCYCLE:   wr_val_s = csr_wdata_i;
      CSR_MTIMECMP: wr_val_s = csr_wdata_i;
      default:      wr_ok_s  = 1'b0;
    endcase
  end

  // Storage read mux.
  always_comb begin
    rd_stored_s = '0;
    case (csr_raddr_i)
      CSR_MSTATUS:  rd_stored_s = pack_mstatus(mst_mie_r, mst_mpie_r);
      CSR_MIE:      rd_stored_s = pack_irq_bits(mie_mtie_r, mie_meie_r);
      CSR_MTVEC:    rd_stored_s = mtvec_r;
      CSR_MEPC:     rd_stored_s = mepc_r;
      CSR_MCAUSE:   rd_stored_s = mcause_r;
      CSR_MIP:      rd_stored_s = pack_irq_bits(mtip_s, irq_ext_i);
      CSR_MCYCLE:   rd_stored_s = mcycle_r;
      CSR_MTIMECMP: rd_stored_s = mtimecmp_r;
      default:      rd_stored_s = '0;
    endcase
  end

  // Same-cycle write to the address being read is forwarded.
  always_comb begin
    if (csr_we_i && wr_ok_s && (csr_waddr_i == csr_raddr_i)) begin
      csr_rdata_o = wr_val_s;
    end else begin
      csr_rdata_o = rd_stored_s;
    end
  end

  // CSR storage; trap/mret updates are placed last so they win over a software write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mst_mie_r  <= 1'b0;
      mst_mpie_r <= 1'b0;
      mie_mtie_r <= 1'b0;
      mie_meie_r <= 1'b0;
      mtvec_r    <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
      mtimecmp_r <= MTIMECMP_RST;
    end else begin
      if (csr_we_i) begin
        case (csr_waddr_i)
          CSR_MSTATUS: begin
            mst_mie_r  <= csr_wdata_i[MSTATUS_MIE_BIT];
            mst_mpie_r <= csr_wdata_i[MSTATUS_MPIE_BIT];
          end
          CSR_MIE: begin
            mie_mtie_r <= csr_wdata_i[IRQ_TIMER_BIT];
            mie_meie_r <= csr_wdata_i[IRQ_EXT_BIT];
          end
          CSR_MTVEC:    mtvec_r    <= wr_val_s;
          CSR_MEPC:     mepc_r     <= wr_val_s;
          CSR_MCAUSE:   mcause_r   <= wr_val_s;
          CSR_MTIMECMP: mtimecmp_r <= wr_val_s;
          default: ;
        endcase
      end
      if (trap_take_s) begin
        mepc_r     <= align4(inst_pc_i);
        mcause_r   <= cause_s;
        mst_mpie_r <= mst_mie_r;
        mst_mie_r  <= 1'b0;
      end else if (mret_take_s) begin
        mst_mie_r  <= mst_mpie_r;
        mst_mpie_r <= 1'b1;
      end
    end
  end

  // Free-running cycle counter; a software write replaces the increment.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcycle_r <= '0;
    end else if (csr_we_i && (csr_waddr_i == CSR_MCYCLE)) begin
      mcycle_r <= csr_wdata_i;
    end else begin
      mcycle_r <= mcycle_r + DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_csr_reg.sv
// Self-checking bench for csr_reg: inline CSR read checks plus a scoreboard of
// expected redirect targets popped on every flush pulse.
module tb_csr_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        irq_ext_i;
  logic [31:0] inst_pc_i;
  logic        mret_i;
  logic        flush_interrupt_o;
  logic [31:0] trap_pc_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] mon_exp;
  logic [31:0] rdv;

  csr_reg #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .csr_we_i         (csr_we_i),
    .csr_waddr_i      (csr_waddr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_raddr_i      (csr_raddr_i),
    .csr_rdata_o      (csr_rdata_o),
    .irq_ext_i        (irq_ext_i),
    .inst_pc_i        (inst_pc_i),
    .mret_i           (mret_i),
    .flush_interrupt_o(flush_interrupt_o),
    .trap_pc_o        (trap_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Every flush pulse must carry the oldest outstanding expected target.
  always @(negedge clk_i) begin
    if (flush_interrupt_o === 1'b1) begin
      tests_run++;
      if (exp_pc_q.size() == 0) begin
        tests_failed++;
        $display("FAIL flush_unexpected: trap_pc %h, no flush expected", trap_pc_o);
      end else begin
        mon_exp = exp_pc_q.pop_front();
        if (trap_pc_o !== mon_exp) begin
          tests_failed++;
          $display("FAIL trap_pc: got %h expected %h", trap_pc_o, mon_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_raddr_i = a;
    #1;
    d = csr_rdata_o;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_waddr_i = a;
    csr_wdata_i = d;
    tick();
    csr_we_i    = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                               12'h344, 12'hB00, 12'h7C0, 12'h123};
    logic [31:0] exps  [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    rst_i = 1'b0; csr_we_i = 1'b0; csr_waddr_i = 12'h0; csr_wdata_i = 32'h0;
    csr_raddr_i = 12'h0; irq_ext_i = 1'b0; inst_pc_i = 32'h0; mret_i = 1'b0;
    tick(); tick();
    tests_run++;
    if (flush_interrupt_o !== 1'b0 || trap_pc_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: flush %b trap_pc %h expected 0 0", flush_interrupt_o, trap_pc_o);
    end
    for (int i = 0; i < 9; i++) begin
      rd(addrs[i], rdv);
      tests_run++;
      if (rdv !== exps[i]) begin
        tests_failed++;
        $display("FAIL reset_csr_%h: got %h expected %h", addrs[i], rdv, exps[i]);
      end
      tick();
    end
    rst_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      rd(12'hB00, rdv);
      tests_run++;
      if (rdv !== 32'(k)) begin
        tests_failed++;
        $display("FAIL mcycle_count: got %h expected %h", rdv, 32'(k));
      end
    end
  endtask

  task automatic test_bypass;
    csr_we_i = 1'b1; csr_waddr_i = 12'h305; csr_wdata_i = 32'h0000_0103;
    rd(12'h305, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL bypass_mtvec: got %h expected %h", rdv, 32'h0000_0100);
    end
    tick();
    csr_we_i = 1'b0;
    rd(12'h305, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL stored_mtvec: got %h expected %h", rdv, 32'h0000_0100);
    end
    csr_we_i = 1'b1; csr_waddr_i = 12'h344; csr_wdata_i = 32'hFFFF_FFFF;
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL mip_bypass: got %h expected %h", rdv, 32'h0);
    end
    tick();
    csr_waddr_i = 12'h123;
    rd(12'h123, rdv);
    tick();
    csr_we_i = 1'b0;
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL mip_readonly: got %h expected %h", rdv, 32'h0);
    end
    rd(12'h123, rdv);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL unimpl_read: got %h expected %h", rdv, 32'h0);
    end
  endtask

  task automatic test_ext_irq;
    wr(12'h305, 32'h0000_0100);
    wr(12'h304, 32'h0000_0800);
    inst_pc_i = 32'h0000_0040;
    wr(12'h300, 32'h0000_0008);
    irq_ext_i = 1'b1;
    exp_pc_q.push_back(32'h0000_0100);
    tick();
    irq_ext_i = 1'b0;
    tests_run++;
    if (flush_interrupt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ext_flush: got %b expected 1", flush_interrupt_o);
    end
    rd(12'h341, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0040) begin
      tests_failed++;
      $display("FAIL ext_mepc: got %h expected %h", rdv, 32'h0000_0040);
    end
    rd(12'h342, rdv);
    tests_run++;
    if (rdv !== 32'h8000_000B) begin
      tests_failed++;
      $display("FAIL ext_mcause: got %h expected %h", rdv, 32'h8000_000B);
    end
    rd(12'h300, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL ext_mstatus: got %h expected %h", rdv, 32'h0000_0080);
    end
    tick();
    tests_run++;
    if (flush_interrupt_o !== 1'b0 || trap_pc_o !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL ext_pulse_end: flush %b trap_pc %h expected 0 00000100", flush_interrupt_o, trap_pc_o);
    end
    tick();
  endtask

  task automatic test_priority;
    logic [31:0] c;
    wr(12'h304, 32'h0000_0880);
    rd(12'hB00, c);
    wr(12'h7C0, c + 32'd5);
    repeat (3) tick();
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL mtip_early: got %h expected %h", rdv, 32'h0);
    end
    tick();
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL mtip_set: got %h expected %h", rdv, 32'h0000_0080);
    end
    irq_ext_i = 1'b1;
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0880) begin
      tests_failed++;
      $display("FAIL mip_both: got %h expected %h", rdv, 32'h0000_0880);
    end
    exp_pc_q.push_back(32'h0000_0100);
    wr(12'h300, 32'h0000_0008);
    tick();
    irq_ext_i = 1'b0;
    rd(12'h342, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b1 || rdv !== 32'h8000_000B) begin
      tests_failed++;
      $display("FAIL prio_ext: flush %b mcause %h expected 1 8000000b", flush_interrupt_o, rdv);
    end
    tick(); tick();
    exp_pc_q.push_back(32'h0000_0100);
    wr(12'h300, 32'h0000_0008);
    tick();
    rd(12'h342, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b1 || rdv !== 32'h8000_0007) begin
      tests_failed++;
      $display("FAIL prio_timer: flush %b mcause %h expected 1 80000007", flush_interrupt_o, rdv);
    end
    tick(); tick();
    wr(12'h304, 32'h0);
    wr(12'h7C0, 32'hFFFF_FFFF);
  endtask

  task automatic test_mret;
    wr(12'h341, 32'h0000_0044);
    wr(12'h300, 32'h0000_0080);
    exp_pc_q.push_back(32'h0000_0044);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tests_run++;
    if (flush_interrupt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mret_flush: got %b expected 1", flush_interrupt_o);
    end
    tick();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    rd(12'h300, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b0 || rdv !== 32'h0000_0088) begin
      tests_failed++;
      $display("FAIL mret_settle: flush %b mstatus %h expected 0 00000088", flush_interrupt_o, rdv);
    end
    tests_run++;
    if (trap_pc_o !== 32'h0000_0044) begin
      tests_failed++;
      $display("FAIL trap_pc_hold: got %h expected %h", trap_pc_o, 32'h0000_0044);
    end
  endtask

  task automatic test_same_edge;
    wr(12'h304, 32'h0000_0800);
    inst_pc_i = 32'h0000_0080;
    irq_ext_i = 1'b1;
    csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h0000_0008;
    exp_pc_q.push_back(32'h0000_0100);
    tick();
    csr_we_i = 1'b0; irq_ext_i = 1'b0;
    rd(12'h300, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b1 || rdv !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL same_edge_mstatus: flush %b mstatus %h expected 1 00000080", flush_interrupt_o, rdv);
    end
    rd(12'h341, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL same_edge_mepc: got %h expected %h", rdv, 32'h0000_0080);
    end
    tick(); tick();
    wr(12'h300, 32'h0000_0008);
    irq_ext_i = 1'b1;
    csr_we_i = 1'b1; csr_waddr_i = 12'h305; csr_wdata_i = 32'h0000_0200;
    exp_pc_q.push_back(32'h0000_0100);
    tick();
    csr_we_i = 1'b0; irq_ext_i = 1'b0;
    rd(12'h305, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b1 || rdv !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL same_edge_mtvec: flush %b mtvec %h expected 1 00000200", flush_interrupt_o, rdv);
    end
    tick(); tick();
  endtask

  task automatic test_mcycle_wrap;
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, rdv);
    tests_run++;
    if (rdv !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL mcycle_load: got %h expected %h", rdv, 32'hFFFF_FFFF);
    end
    rd(12'h344, rdv);
    tests_run++;
    if (rdv !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL mtip_equal: got %h expected %h", rdv, 32'h0000_0080);
    end
    tick();
    rd(12'hB00, rdv);
    tests_run++;
    if (rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL mcycle_wrap: got %h expected %h", rdv, 32'h0);
    end
  endtask

  task automatic test_reset_mid_trap;
    wr(12'h300, 32'h0000_0008);
    irq_ext_i = 1'b1;
    exp_pc_q.push_back(32'h0000_0200);
    tick();
    irq_ext_i = 1'b0;
    tests_run++;
    if (flush_interrupt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_trap_flush: got %b expected 1", flush_interrupt_o);
    end
    rst_i = 1'b0;
    tick();
    rd(12'h300, rdv);
    tests_run++;
    if (flush_interrupt_o !== 1'b0 || trap_pc_o !== 32'h0 || rdv !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_trap_reset: flush %b trap_pc %h mstatus %h expected 0 0 0",
               flush_interrupt_o, trap_pc_o, rdv);
    end
    rst_i = 1'b1;
    tick(); tick();
    tests_run++;
    if (flush_interrupt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_flush: got %b expected 0", flush_interrupt_o);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ext_irq();
    test_priority();
    test_mret();
    test_same_edge();
    test_mcycle_wrap();
    test_reset_mid_trap();
    tick();
    tests_run++;
    if (exp_pc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d flushes missing, expected 0", exp_pc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
